// File: rtl/instruction_decode_if.sv
// Fetch/decode/EX-facing bus of the decode stage: IR/PC in, write-back in,
// registered ID/EX bundle and branch control out.
interface instruction_decode_if;
  logic [31:0] IR;
  logic [31:0] PC;
  logic        alu_zero;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm_ext;
  logic [4:0]  dest;
  logic [2:0]  alu_op;
  logic        alu_src;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        ex_valid;
  logic        illegal;
  logic [1:0]  J_control2;
  logic [31:0] J_address;

  modport master (
    output IR, PC, alu_zero, wb_en, wb_addr, wb_data,
    input  rs_data, rt_data, imm_ext, dest, alu_op, alu_src, reg_write,
           mem_read, mem_write, mem_to_reg, ex_valid, illegal, J_control2, J_address
  );

  modport slave (
    input  IR, PC, alu_zero, wb_en, wb_addr, wb_data,
    output rs_data, rt_data, imm_ext, dest, alu_op, alu_src, reg_write,
           mem_read, mem_write, mem_to_reg, ex_valid, illegal, J_control2, J_address
  );
endinterface

// File: rtl/instruction_decode.sv
// Decode stage: register file, instruction decode, ID/EX register and j/beq squash FSM.
// Define ID_WB_BYPASS_EN to forward same-cycle write-back data into the operand reads.
module instruction_decode #(
  parameter int unsigned NREG   = 32,
  parameter int unsigned SQ_BEQ = 2,
  parameter int unsigned SQ_J   = 1
) (
  input logic              clk,
  input logic              rst,
  instruction_decode_if.slave bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = $clog2(NREG);
  localparam int unsigned SQMAX = (SQ_BEQ > SQ_J) ? SQ_BEQ : SQ_J;
  localparam int unsigned CW    = $clog2(SQMAX + 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  typedef enum logic [1:0] {IDLE, BR_EX, SQUASH} state_t;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [2:0] alu_op;
    logic [4:0] dest;
  } ctrl_t;

  logic [5:0]    op;
  logic [5:0]    funct;
  logic [AW-1:0] rs;
  logic [AW-1:0] rt;
  logic [AW-1:0] rd;
  logic [XLEN-1:0] imm_sext;

  assign op       = bus.IR[31:26];
  assign funct    = bus.IR[5:0];
  assign rs       = bus.IR[25:21];
  assign rt       = bus.IR[20:16];
  assign rd       = bus.IR[15:11];
  assign imm_sext = {{16{bus.IR[15]}}, bus.IR[15:0]};

  // Register file: two async reads, one sync write, $0 hardwired to zero
  logic [XLEN-1:0] rf [NREG];
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
    end else if (bus.wb_en && (bus.wb_addr != '0)) begin
      rf[bus.wb_addr] <= bus.wb_data;
    end
  end

`ifdef ID_WB_BYPASS_EN
  always_comb begin
    rs_val = rf[rs];
    rt_val = rf[rt];
    if (bus.wb_en && (bus.wb_addr == rs)) rs_val = bus.wb_data;
    if (bus.wb_en && (bus.wb_addr == rt)) rt_val = bus.wb_data;
    if (rs == '0) rs_val = '0;
    if (rt == '0) rt_val = '0;
  end
`else
  always_comb begin
    rs_val = (rs == '0) ? '0 : rf[rs];
    rt_val = (rt == '0) ? '0 : rf[rt];
  end
`endif

  // Instruction decode into the control bundle
  ctrl_t dec;
  logic  dec_illegal;
  logic  is_beq;
  logic  is_j;

  always_comb begin
    dec         = '0;
    dec.dest    = rt;
    dec.alu_op  = ALU_ADD;
    dec_illegal = 1'b0;
    is_beq      = 1'b0;
    is_j        = 1'b0;
    case (op)
      OP_RTYPE: begin
        if (bus.IR != '0) begin
          dec.valid     = 1'b1;
          dec.reg_write = 1'b1;
          dec.dest      = rd;
          case (funct)
            FN_ADD:  dec.alu_op = ALU_ADD;
            FN_SUB:  dec.alu_op = ALU_SUB;
            FN_AND:  dec.alu_op = ALU_AND;
            FN_OR:   dec.alu_op = ALU_OR;
            FN_SLT:  dec.alu_op = ALU_SLT;
            default: begin
              dec.valid     = 1'b0;
              dec.reg_write = 1'b0;
              dec_illegal   = 1'b1;
            end
          endcase
        end
      end
      OP_ADDI: begin
        dec.valid     = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_LW: begin
        dec.valid      = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        dec.valid     = 1'b1;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec.valid  = 1'b1;
        dec.alu_op = ALU_SUB;
        is_beq     = 1'b1;
      end
      OP_J: begin
        is_j = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Branch/squash FSM
  state_t        state;
  state_t        next_state;
  logic [CW-1:0] count;
  logic [CW-1:0] next_count;
  logic          squash;
  logic          load_target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= next_state;
      count <= next_count;
    end
  end

  always_comb begin
    next_state  = state;
    next_count  = count;
    squash      = 1'b0;
    load_target = 1'b0;
    case (state)
      IDLE: begin
        if (is_beq) begin
          next_state  = BR_EX;
          load_target = 1'b1;
        end else if (is_j) begin
          next_state = SQUASH;
          next_count = CW'(SQ_J);
        end
      end
      BR_EX: begin
        // beq now in EX: alu_zero resolves it
        if (bus.alu_zero) begin
          next_state = SQUASH;
          next_count = CW'(SQ_BEQ);
        end else if (is_j) begin
          next_state = SQUASH;
          next_count = CW'(SQ_J);
        end else if (is_beq) begin
          next_state  = BR_EX;
          load_target = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      SQUASH: begin
        squash     = 1'b1;
        next_count = count - CW'(1);
        if (count <= CW'(1)) begin
          next_state = IDLE;
          next_count = '0;
        end
      end
      default: begin
        next_state = IDLE;
        next_count = '0;
      end
    endcase
  end

  // ID/EX register
  ctrl_t           ctrl_q;
  logic [XLEN-1:0] rs_q;
  logic [XLEN-1:0] rt_q;
  logic [XLEN-1:0] imm_q;
  logic            illegal_q;
  logic [1:0]      jc_q;
  logic [XLEN-1:0] ja_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
      jc_q      <= 2'd0;
      ja_q      <= '0;
    end else begin
      ctrl_q    <= squash ? ctrl_t'('0) : dec;
      rs_q      <= rs_val;
      rt_q      <= rt_val;
      imm_q     <= imm_sext;
      illegal_q <= dec_illegal && !squash;
      jc_q      <= (next_state == BR_EX) ? 2'd1 : 2'd0;
      // PC is already the beq address + 4
      if (load_target) ja_q <= bus.PC + {imm_sext[XLEN-3:0], 2'b00};
    end
  end

  assign bus.rs_data    = rs_q;
  assign bus.rt_data    = rt_q;
  assign bus.imm_ext    = imm_q;
  assign bus.dest       = ctrl_q.dest;
  assign bus.alu_op     = ctrl_q.alu_op;
  assign bus.alu_src    = ctrl_q.alu_src;
  assign bus.reg_write  = ctrl_q.reg_write;
  assign bus.mem_read   = ctrl_q.mem_read;
  assign bus.mem_write  = ctrl_q.mem_write;
  assign bus.mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.ex_valid   = ctrl_q.valid;
  assign bus.illegal    = illegal_q;
  assign bus.J_control2 = jc_q;
  assign bus.J_address  = ja_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: decode table, register file, j/beq squash and reset.
module tb_instruction_decode;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_decode_if bus ();

  instruction_decode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Apply one decode slot and sample #1 after the capturing edge
  task automatic drive(input logic [31:0] ir, input logic [31:0] pc, input logic az,
                       input logic wen, input logic [4:0] waddr, input logic [31:0] wdata);
    bus.IR       = ir;
    bus.PC       = pc;
    bus.alu_zero = az;
    bus.wb_en    = wen;
    bus.wb_addr  = waddr;
    bus.wb_data  = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    drive(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    checks++;
    if ({bus.ex_valid, bus.reg_write, bus.mem_read, bus.mem_write, bus.mem_to_reg,
         bus.alu_src, bus.illegal, bus.alu_op, bus.dest, bus.J_control2} !== 15'h0) begin
      errors++;
      $display("FAIL reset_ctrl got ex_valid=%b reg_write=%b alu_op=%0d dest=%0d J_control2=%0d want all 0",
               bus.ex_valid, bus.reg_write, bus.alu_op, bus.dest, bus.J_control2);
    end
    checks++;
    if ({bus.rs_data, bus.rt_data, bus.imm_ext, bus.J_address} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data got rs=%h rt=%h imm=%h ja=%h want 0", bus.rs_data, bus.rt_data,
               bus.imm_ext, bus.J_address);
    end
    rst = 1'b0;
  endtask

  task automatic test_regfile_add;
    drive(32'h0, 32'h0, 1'b0, 1'b1, 5'd3, 32'd7);
    drive(32'h0, 32'h0, 1'b0, 1'b1, 5'd1, 32'd5);
    drive(32'h0, 32'h0, 1'b0, 1'b1, 5'd2, 32'h20);
    drive(rtype(5'd3, 5'd3, 5'd4, 6'h20), 32'h4, 1'b0, 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.rs_data !== 32'd7 || bus.rt_data !== 32'd7) begin
      errors++;
      $display("FAIL add_operands got rs=%h rt=%h want 7 7", bus.rs_data, bus.rt_data);
    end
    checks++;
    if ({bus.alu_op, bus.dest, bus.reg_write, bus.ex_valid, bus.alu_src} !== {3'd0, 5'd4, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_ctrl got alu_op=%0d dest=%0d reg_write=%b ex_valid=%b alu_src=%b want 0 4 1 1 0",
               bus.alu_op, bus.dest, bus.reg_write, bus.ex_valid, bus.alu_src);
    end
  endtask

  task automatic test_zero_reg;
    drive(32'h0, 32'h0, 1'b0, 1'b1, 5'd0, 32'hFFFF);
    drive(rtype(5'd0, 5'd0, 5'd13, 6'h20), 32'h8, 1'b0, 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.rs_data !== 32'h0 || bus.rt_data !== 32'h0) begin
      errors++;
      $display("FAIL zero_reg got rs=%h rt=%h want 0 0", bus.rs_data, bus.rt_data);
    end
  endtask

  task automatic test_same_cycle_wb;
    logic [31:0] exp_first;
`ifdef ID_WB_BYPASS_EN
    exp_first = 32'd9;
`else
    exp_first = 32'd7;
`endif
    drive(rtype(5'd3, 5'd3, 5'd5, 6'h20), 32'hC, 1'b0, 1'b1, 5'd3, 32'd9);
    checks++;
    if (bus.rs_data !== exp_first || bus.rt_data !== exp_first) begin
      errors++;
      $display("FAIL same_cycle_wb got rs=%h rt=%h want %h", bus.rs_data, bus.rt_data, exp_first);
    end
    drive(rtype(5'd3, 5'd3, 5'd5, 6'h20), 32'h10, 1'b0, 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.rs_data !== 32'd9) begin
      errors++;
      $display("FAIL wb_settled got rs=%h want 9", bus.rs_data);
    end
  endtask

  task automatic test_decode;
    // ctrl = {ex_valid, reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op, dest}
    logic [31:0] irs   [7];
    logic [13:0] ctrl  [7];
    logic [31:0] imms  [7];
    logic [31:0] rtv   [7];
    logic [13:0] got;
    irs[0] = rtype(5'd1, 5'd2, 5'd6, 6'h22);    ctrl[0] = {6'b110000, 3'd1, 5'd6};  imms[0] = 32'h3022;     rtv[0] = 32'h20;
    irs[1] = rtype(5'd1, 5'd2, 5'd7, 6'h24);    ctrl[1] = {6'b110000, 3'd2, 5'd7};  imms[1] = 32'h3824;     rtv[1] = 32'h20;
    irs[2] = rtype(5'd1, 5'd2, 5'd8, 6'h25);    ctrl[2] = {6'b110000, 3'd3, 5'd8};  imms[2] = 32'h4025;     rtv[2] = 32'h20;
    irs[3] = rtype(5'd1, 5'd2, 5'd9, 6'h2A);    ctrl[3] = {6'b110000, 3'd4, 5'd9};  imms[3] = 32'h482A;     rtv[3] = 32'h20;
    irs[4] = itype(6'h08, 5'd1, 5'd10, 16'hFFFC); ctrl[4] = {6'b110001, 3'd0, 5'd10}; imms[4] = 32'hFFFFFFFC; rtv[4] = 32'h0;
    irs[5] = itype(6'h23, 5'd1, 5'd11, 16'h0008); ctrl[5] = {6'b111011, 3'd0, 5'd11}; imms[5] = 32'h8;        rtv[5] = 32'h0;
    irs[6] = itype(6'h2B, 5'd1, 5'd12, 16'h0004); ctrl[6] = {6'b100101, 3'd0, 5'd12}; imms[6] = 32'h4;        rtv[6] = 32'h0;
    for (int i = 0; i < 7; i++) begin
      drive(irs[i], 32'h40 + 32'(i * 4), 1'b0, 1'b0, 5'd0, 32'h0);
      got = {bus.ex_valid, bus.reg_write, bus.mem_read, bus.mem_write, bus.mem_to_reg,
             bus.alu_src, bus.alu_op, bus.dest};
      checks++;
      if (got !== ctrl[i] || bus.imm_ext !== imms[i] || bus.rs_data !== 32'd5 ||
          bus.rt_data !== rtv[i] || bus.illegal !== 1'b0) begin
        errors++;
        $display("FAIL decode_%0d got ctrl=%h imm=%h rs=%h rt=%h ill=%b want ctrl=%h imm=%h rs=5 rt=%h ill=0",
                 i, got, bus.imm_ext, bus.rs_data, bus.rt_data, bus.illegal, ctrl[i], imms[i], rtv[i]);
      end
    end
  endtask

  task automatic test_beq_taken;
    logic [31:0] add_ir;
    add_ir = rtype(5'd3, 5'd3, 5'd4, 6'h20);
    drive(itype(6'h04, 5'd1, 5'd2, 16'd3), 32'h14, 1'b0, 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.J_control2 !== 2'd1 || bus.J_address !== 32'h20 || bus.ex_valid !== 1'b1 ||
        bus.alu_op !== 3'd1 || bus.reg_write !== 1'b0) begin
      errors++;
      $display("FAIL beq_issue got jc=%0d ja=%h ev=%b op=%0d rw=%b want 1 00000020 1 1 0",
               bus.J_control2, bus.J_address, bus.ex_valid, bus.alu_op, bus.reg_write);
    end
    drive(add_ir, 32'h18, 1'b1, 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.J_control2 !== 2'd0 || bus.ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL beq_resolve got jc=%0d ev=%b want 0 1", bus.J_control2, bus.ex_valid);
    end
    for (int i = 0; i < 2; i++) begin
      drive(add_ir, 32'h20 + 32'(i * 4), 1'b0, 1'b0, 5'd0, 32'h0);
      checks++;
      if (bus.ex_valid !== 1'b0 || bus.reg_write !== 1'b0 || bus.J_control2 !== 2'd0) begin
        errors++;
        $display("FAIL beq_squash_%0d got ev=%b rw=%b jc=%0d want 0 0 0", i, bus.ex_valid,
                 bus.reg_write, bus.J_control2);
      end
    end
    drive(add_ir, 32'h28, 1'b0, 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL beq_after_squash got ev=%b want 1", bus.ex_valid);
    end
  endtask

  task automatic test_beq_not_taken;
    logic [31:0] add_ir;
    add_ir = rtype(5'd3, 5'd3, 5'd4, 6'h20);
    drive(itype(6'h04, 5'd1, 5'd2, 16'hFFFF), 32'h100, 1'b0, 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.J_control2 !== 2'd1 || bus.J_address !== 32'hFC) begin
      errors++;
      $display("FAIL beq_neg_target got jc=%0d ja=%h want 1 000000fc", bus.J_control2, bus.J_address);
    end
    for (int i = 0; i < 3; i++) begin
      drive(add_ir, 32'h104 + 32'(i * 4), 1'b0, 1'b0, 5'd0, 32'h0);
      checks++;
      if (bus.ex_valid !== 1'b1 || bus.J_control2 !== 2'd0) begin
        errors++;
        $display("FAIL beq_nt_%0d got ev=%b jc=%0d want 1 0", i, bus.ex_valid, bus.J_control2);
      end
    end
  endtask

  task automatic test_jump;
    logic [31:0] add_ir;
    add_ir = rtype(5'd3, 5'd3, 5'd4, 6'h20);
    drive({6'h02, 26'h10}, 32'h200, 1'b0, 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.illegal !== 1'b0 || bus.J_control2 !== 2'd0) begin
      errors++;
      $display("FAIL j_bubble got ev=%b ill=%b jc=%0d want 0 0 0", bus.ex_valid, bus.illegal, bus.J_control2);
    end
    drive(add_ir, 32'h204, 1'b0, 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL j_squash got ev=%b want 0", bus.ex_valid);
    end
    drive(add_ir, 32'h44, 1'b0, 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL j_resume got ev=%b want 1", bus.ex_valid);
    end
  endtask

  task automatic test_illegal;
    drive(32'hFC000000, 32'h48, 1'b0, 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.illegal !== 1'b1 || bus.ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL illegal_op got ill=%b ev=%b want 1 0", bus.illegal, bus.ex_valid);
    end
    drive(32'h0, 32'h4C, 1'b0, 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.illegal !== 1'b0 || bus.ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL nop got ill=%b ev=%b want 0 0", bus.illegal, bus.ex_valid);
    end
    drive(rtype(5'd1, 5'd2, 5'd3, 6'h3F), 32'h50, 1'b0, 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.illegal !== 1'b1 || bus.ex_valid !== 1'b0 || bus.reg_write !== 1'b0) begin
      errors++;
      $display("FAIL illegal_funct got ill=%b ev=%b rw=%b want 1 0 0", bus.illegal, bus.ex_valid, bus.reg_write);
    end
  endtask

  task automatic test_squashed_branch;
    drive({6'h02, 26'h20}, 32'h300, 1'b0, 1'b0, 5'd0, 32'h0);
    drive(itype(6'h04, 5'd1, 5'd1, 16'd5), 32'h304, 1'b0, 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.J_control2 !== 2'd0) begin
      errors++;
      $display("FAIL squashed_beq got ev=%b jc=%0d want 0 0", bus.ex_valid, bus.J_control2);
    end
    drive(rtype(5'd1, 5'd2, 5'd6, 6'h20), 32'h84, 1'b1, 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.J_control2 !== 2'd0) begin
      errors++;
      $display("FAIL post_squash got ev=%b jc=%0d want 1 0", bus.ex_valid, bus.J_control2);
    end
    drive(rtype(5'd1, 5'd2, 5'd6, 6'h20), 32'h88, 1'b0, 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL no_stale_squash got ev=%b want 1", bus.ex_valid);
    end
  endtask

  task automatic test_mid_reset;
    drive(32'h0, 32'h0, 1'b0, 1'b1, 5'd5, 32'h55);
    drive(itype(6'h04, 5'd1, 5'd2, 16'd3), 32'h14, 1'b0, 1'b0, 5'd0, 32'h0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.J_control2 !== 2'd0 || bus.ex_valid !== 1'b0 || bus.J_address !== 32'h0 ||
        bus.rs_data !== 32'h0 || bus.alu_op !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset got jc=%0d ev=%b ja=%h rs=%h op=%0d want all 0", bus.J_control2,
               bus.ex_valid, bus.J_address, bus.rs_data, bus.alu_op);
    end
    bus.alu_zero = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    drive(rtype(5'd5, 5'd5, 5'd6, 6'h20), 32'h18, 1'b1, 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.rs_data !== 32'h0 || bus.ex_valid !== 1'b1 || bus.J_control2 !== 2'd0) begin
      errors++;
      $display("FAIL post_reset got rs=%h ev=%b jc=%0d want 0 1 0", bus.rs_data, bus.ex_valid, bus.J_control2);
    end
    drive(rtype(5'd5, 5'd5, 5'd6, 6'h20), 32'h1C, 1'b0, 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_aborts_squash got ev=%b want 1", bus.ex_valid);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.IR       = '0;
    bus.PC       = '0;
    bus.alu_zero = 1'b0;
    bus.wb_en    = 1'b0;
    bus.wb_addr  = '0;
    bus.wb_data  = '0;
    test_reset();
    test_regfile_add();
    test_zero_reg();
    test_same_cycle_wb();
    test_decode();
    test_beq_taken();
    test_beq_not_taken();
    test_jump();
    test_illegal();
    test_squashed_branch();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
